id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded operands, register addresses and control bits from ID; presents them to EX, including the rs1/rs2/rd addresses that forwarding compares against MEM/WB destinations.
- Load-use hazards (EX-stage load whose destination is read by the ID instruction) are not forwardable, so this block stalls PC and IF/ID and inserts a one-cycle bubble into EX.

Parameters:
- XLEN, 32, data/immediate width.
- RA_W, 5, register address width.
- CTRL_W, 8, packed control-vector width (layout in shared package).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- hold_i  in  1  external freeze, e.g. memory wait; ID/EX keeps its contents.
- flush_i  in  1  kill the ID instruction; load a bubble.
- valid_id_i  in  1  ID slot holds a real instruction.
- rs1_addr_id_i, rs2_addr_id_i, rd_addr_id_i  in  RA_W each  ID register addresses.
- rs1_used_id_i, rs2_used_id_i  in  1 each  instruction actually reads rs1/rs2.
- rs1_data_id_i, rs2_data_id_i, imm_id_i  in  XLEN each  ID operands.
- ctrl_id_i  in  CTRL_W  control vector: regwrite, memtoreg, memread, memwrite, alusrc, aluop[2:0].
- valid_ex_o  out  1  EX slot holds a real instruction.
- rs1_addr_ex_o, rs2_addr_ex_o, rd_addr_ex_o  out  RA_W each  to forwarding and EX.
- rs1_data_ex_o, rs2_data_ex_o, imm_ex_o  out  XLEN each.
- ctrl_ex_o  out  CTRL_W.
- stall_o  out  1  hold PC and IF/ID this cycle.

Behaviour:
- Reset (rst_i low, asynchronous): all outputs and registers are 0. The EX slot is a bubble and stall_o = 0.
- Load-use detect: the check is combinational from the registered EX state and the current ID inputs.
  - load_use = valid_ex_o && ctrl_ex_o.memread && (rd_addr_ex_o != 0) && valid_id_i && ((rs1_used_id_i && rs1_addr_id_i == rd_addr_ex_o) || (rs2_used_id_i && rs2_addr_id_i == rd_addr_ex_o)).
  - stall_o = load_use && !flush_i.
- Next-state priority, highest first:
  1. hold_i = 1: all registers keep their value. stall_o is still driven from the held state.
  2. flush_i = 1 or load_use = 1: load a bubble (valid = 0, ctrl = 0, all addresses = 0, data = 0).
  3. Otherwise: capture all ID inputs; valid_ex_o <= valid_id_i.
- A bubble has ctrl = 0, so regwrite = 0 and the downstream forwarding unit never matches on it.
- Load-use stall lasts exactly one cycle. After the bubble, valid_ex_o = 0, load_use drops, and the ID instruction (still held in IF/ID) is captured on the next edge.
- rd = x0 never triggers a stall. An operand whose used flag is 0 never triggers a stall.
- Back-to-back loads with a dependency: each dependent instruction stalls exactly once.
- Invalid ID slot (valid_id_i = 0): no stall; the register captures a bubble-equivalent (valid = 0).
- Reset asserted mid-stall: immediate clear; stall_o goes low asynchronously.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o [31:0], reset to 0.
  - Increments on every rising edge where load_use && !hold_i && !flush_i.
  - Saturates at 0xFFFFFFFF.
- When undefined: no port, no counter logic.

Decomposition:
- Shared package pipe_pkg:
  - Bit indices CTRL_REGWRITE, CTRL_MEMTOREG, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_ALUSRC, CTRL_ALUOP_LO/HI.
  - CTRL_W.
  - Constant CTRL_BUBBLE = 0.
- Sub-module hazard_detect (combinational load_use/stall_o equation). It is instantiated here and reusable for a later branch-in-ID hazard extension.

Test Plan:
- Reset: hold rst_i low with random inputs → all outputs 0 and stall_o = 0. Release → first capture on the next edge.
- Load-use: EX holds `lw x5` (memread=1, rd=5). ID issues `add x6,x5,x7` (rs1_used=1) → stall_o = 1 for one cycle and EX receives a bubble. Next edge captures the add with rs1_addr_ex_o = 5; stall_o = 0.
- No false stall:
  - `lw x0` followed by a read of x0 → stall_o = 0.
  - `lw x5` followed by `lui x5` (rs1_used = 0, rs2_used = 0) → stall_o = 0.
  - `add x5` (memread = 0) followed by a read of x5 → stall_o = 0 and a normal capture.
- Hold over hazard: load-use present with hold_i = 1 for 3 cycles → EX registers unchanged and stall_o = 1 throughout. Release → bubble, then the instruction.
- Flush vs stall: load_use and flush_i in the same cycle → bubble, stall_o = 0. Next cycle captures the fresh ID instruction.
- ID_EX_STALL_CNT_EN: 4 separate load-use events, one of them under hold for 2 cycles → stall_cnt_o = 4. Preload near max (force) → saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, control-vector bit layout and
// the ID/EX payload struct used by the ID/EX register and its interface.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned CTRL_W = 8;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_ALUSRC   = 4;
  localparam int unsigned CTRL_ALUOP_LO = 5;
  localparam int unsigned CTRL_ALUOP_HI = 7;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef struct packed {
    logic              valid;
    logic [RA_W-1:0]   rs1_addr;
    logic [RA_W-1:0]   rs2_addr;
    logic [RA_W-1:0]   rd_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  // A bubble is all-zero: invalid, no control side effects, x0 everywhere.
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side operands and pipeline controls in, EX-side
// registered slot and the load-use stall out.
interface id_ex_stage_if;
  import pipe_pkg::*;

  logic              hold_i;
  logic              flush_i;
  logic              valid_id_i;
  logic [RA_W-1:0]   rs1_addr_id_i;
  logic [RA_W-1:0]   rs2_addr_id_i;
  logic [RA_W-1:0]   rd_addr_id_i;
  logic              rs1_used_id_i;
  logic              rs2_used_id_i;
  logic [XLEN-1:0]   rs1_data_id_i;
  logic [XLEN-1:0]   rs2_data_id_i;
  logic [XLEN-1:0]   imm_id_i;
  logic [CTRL_W-1:0] ctrl_id_i;

  logic              valid_ex_o;
  logic [RA_W-1:0]   rs1_addr_ex_o;
  logic [RA_W-1:0]   rs2_addr_ex_o;
  logic [RA_W-1:0]   rd_addr_ex_o;
  logic [XLEN-1:0]   rs1_data_ex_o;
  logic [XLEN-1:0]   rs2_data_ex_o;
  logic [XLEN-1:0]   imm_ex_o;
  logic [CTRL_W-1:0] ctrl_ex_o;
  logic              stall_o;

  modport master (
    output hold_i, flush_i, valid_id_i,
    output rs1_addr_id_i, rs2_addr_id_i, rd_addr_id_i,
    output rs1_used_id_i, rs2_used_id_i,
    output rs1_data_id_i, rs2_data_id_i, imm_id_i, ctrl_id_i,
    input  valid_ex_o, rs1_addr_ex_o, rs2_addr_ex_o, rd_addr_ex_o,
    input  rs1_data_ex_o, rs2_data_ex_o, imm_ex_o, ctrl_ex_o, stall_o
  );

  modport slave (
    input  hold_i, flush_i, valid_id_i,
    input  rs1_addr_id_i, rs2_addr_id_i, rd_addr_id_i,
    input  rs1_used_id_i, rs2_used_id_i,
    input  rs1_data_id_i, rs2_data_id_i, imm_id_i, ctrl_id_i,
    output valid_ex_o, rs1_addr_ex_o, rs2_addr_ex_o, rd_addr_ex_o,
    output rs1_data_ex_o, rs2_data_ex_o, imm_ex_o, ctrl_ex_o, stall_o
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: an EX-stage load whose destination is read
// by the ID instruction. Kept standalone so a branch-in-ID check can reuse it.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic            valid_ex,
  input  logic            memread_ex,
  input  logic [RA_W-1:0] rd_addr_ex,
  input  logic            valid_id,
  input  logic            rs1_used_id,
  input  logic [RA_W-1:0] rs1_addr_id,
  input  logic            rs2_used_id,
  input  logic [RA_W-1:0] rs2_addr_id,
  input  logic            flush,
  output logic            load_use_c,
  output logic            stall_c
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_used_id && (rs1_addr_id == rd_addr_ex);
  assign rs2_hit = rs2_used_id && (rs2_addr_id == rd_addr_ex);

  // x0 is never a real producer, so a load into it cannot create a hazard.
  assign load_use_c = valid_ex && memread_ex && (rd_addr_ex != RA_W'(0)) &&
                      valid_id && (rs1_hit || rs2_hit);

  // A flushed ID instruction is being discarded; there is nothing to hold.
  assign stall_c = load_use_c && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion.
// Optional feature macro: ID_EX_STALL_CNT_EN (adds a saturating stall counter).
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  id_ex_stage_if.slave bus
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]  stall_cnt_o
`endif
);

  id_ex_t ex_q;
  id_ex_t id_d;
  logic   load_use;
  logic   stall;

  assign id_d = '{
    valid:    bus.valid_id_i,
    rs1_addr: bus.rs1_addr_id_i,
    rs2_addr: bus.rs2_addr_id_i,
    rd_addr:  bus.rd_addr_id_i,
    rs1_data: bus.rs1_data_id_i,
    rs2_data: bus.rs2_data_id_i,
    imm:      bus.imm_id_i,
    ctrl:     bus.ctrl_id_i
  };

  hazard_detect u_hazard (
    .valid_ex    (ex_q.valid),
    .memread_ex  (ex_q.ctrl[CTRL_MEMREAD]),
    .rd_addr_ex  (ex_q.rd_addr),
    .valid_id    (bus.valid_id_i),
    .rs1_used_id (bus.rs1_used_id_i),
    .rs1_addr_id (bus.rs1_addr_id_i),
    .rs2_used_id (bus.rs2_used_id_i),
    .rs2_addr_id (bus.rs2_addr_id_i),
    .flush       (bus.flush_i),
    .load_use_c  (load_use),
    .stall_c     (stall)
  );

  // Hold freezes everything; flush or load-use injects a bubble; else capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q <= ID_EX_BUBBLE;
    end else if (!bus.hold_i) begin
      if (bus.flush_i || load_use) begin
        ex_q <= ID_EX_BUBBLE;
      end else begin
        ex_q <= id_d;
      end
    end
  end

  assign bus.valid_ex_o    = ex_q.valid;
  assign bus.rs1_addr_ex_o = ex_q.rs1_addr;
  assign bus.rs2_addr_ex_o = ex_q.rs2_addr;
  assign bus.rd_addr_ex_o  = ex_q.rd_addr;
  assign bus.rs1_data_ex_o = ex_q.rs1_data;
  assign bus.rs2_data_ex_o = ex_q.rs2_data;
  assign bus.imm_ex_o      = ex_q.imm;
  assign bus.ctrl_ex_o     = ex_q.ctrl;
  assign bus.stall_o       = stall;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Counts bubbles actually inserted by load-use, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (load_use && !bus.hold_i && !bus.flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus random
// traffic compared against a cycle-level reference model of the EX slot.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  id_ex_stage_if ifc ();

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  id_ex_stage dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (ifc)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the EX slot
  logic        m_valid;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [7:0]  m_ctrl;
  logic [31:0] m_cnt;

  localparam logic [7:0] C_LW   = 8'b0000_0111; // regwrite|memtoreg|memread
  localparam logic [7:0] C_ADD  = 8'b0100_0001; // regwrite, aluop=2
  localparam logic [7:0] C_LUI  = 8'b0001_0001; // regwrite|alusrc

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_load_use();
    logic hit1, hit2;
    hit1 = ifc.rs1_used_id_i && (ifc.rs1_addr_id_i == m_rd);
    hit2 = ifc.rs2_used_id_i && (ifc.rs2_addr_id_i == m_rd);
    return m_valid && m_ctrl[2] && (m_rd != 5'd0) && ifc.valid_id_i && (hit1 || hit2);
  endfunction

  task automatic m_reset();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0;
  endtask

  task automatic m_clock();
    logic lu;
    lu = m_load_use();
    if (!rst_i) begin
      m_reset();
    end else if (!ifc.hold_i) begin
      if (lu && !ifc.flush_i && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (ifc.flush_i || lu) begin
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0; m_ctrl = 0;
      end else begin
        m_valid = ifc.valid_id_i;
        m_rs1 = ifc.rs1_addr_id_i; m_rs2 = ifc.rs2_addr_id_i; m_rd = ifc.rd_addr_id_i;
        m_d1 = ifc.rs1_data_id_i; m_d2 = ifc.rs2_data_id_i; m_imm = ifc.imm_id_i;
        m_ctrl = ifc.ctrl_id_i;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stall"}, 32'(ifc.stall_o), 32'(m_load_use() && !ifc.flush_i));
    chk({tag, ".valid"}, 32'(ifc.valid_ex_o), 32'(m_valid));
    // A captured invalid slot only promises valid=0; compare payload when it matters.
    if (m_valid || !rst_i || (m_ctrl == 8'd0 && m_rd == 5'd0 && m_d1 == 32'd0)) begin
      chk({tag, ".rs1a"}, 32'(ifc.rs1_addr_ex_o), 32'(m_rs1));
      chk({tag, ".rs2a"}, 32'(ifc.rs2_addr_ex_o), 32'(m_rs2));
      chk({tag, ".rda"},  32'(ifc.rd_addr_ex_o),  32'(m_rd));
      chk({tag, ".d1"},   ifc.rs1_data_ex_o, m_d1);
      chk({tag, ".d2"},   ifc.rs2_data_ex_o, m_d2);
      chk({tag, ".imm"},  ifc.imm_ex_o, m_imm);
      chk({tag, ".ctrl"}, 32'(ifc.ctrl_ex_o), 32'(m_ctrl));
    end
`ifdef ID_EX_STALL_CNT_EN
    chk({tag, ".cnt"}, stall_cnt, m_cnt);
`endif
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic [7:0] ctrl);
    ifc.valid_id_i = v;
    ifc.rs1_addr_id_i = rs1; ifc.rs1_used_id_i = u1;
    ifc.rs2_addr_id_i = rs2; ifc.rs2_used_id_i = u2;
    ifc.rd_addr_id_i = rd;   ifc.ctrl_id_i = ctrl;
    ifc.rs1_data_id_i = $urandom; ifc.rs2_data_id_i = $urandom; ifc.imm_id_i = $urandom;
  endtask

  task automatic rand_id();
    set_id(1'($urandom_range(0, 7) != 0),
           5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), 8'($urandom));
  endtask

  // Inputs are applied at the falling edge; outputs are checked just after.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b0;
    ifc.hold_i = 1'b0; ifc.flush_i = 1'b0;
    m_reset();
    rand_id();

    // Reset with random inputs on the ID side
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_id();
      ifc.hold_i = 1'($urandom); ifc.flush_i = 1'($urandom);
      #1 check_all("reset");
    end
    @(negedge clk);
    ifc.hold_i = 0; ifc.flush_i = 0;
    rst_i = 1'b1;
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, C_ADD);
    step("first_cap");
    chk("first_cap.v", 32'(ifc.valid_ex_o), 32'd1);

    // Load-use: lw x5 then add x6,x5,x7
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, C_LW);
    step("lu.lw");
    set_id(1, 5'd5, 1, 5'd7, 1, 5'd6, C_ADD);
    #1 chk("lu.stall_hi", 32'(ifc.stall_o), 32'd1);
    step("lu.stall");
    step("lu.bubble");
    chk("lu.rs1_cap", 32'(ifc.rs1_addr_ex_o), 32'd5);
    step("lu.after");

    // No false stall: lw x0, lui after lw x5, add (no memread) then reader
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, C_LW);
    step("x0.lw");
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd3, C_ADD);
    step("x0.rd");
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, C_LW);
    step("lui.lw");
    set_id(1, 5'd5, 0, 5'd5, 0, 5'd5, C_LUI);
    step("lui.rd");
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, C_ADD);
    step("alu.prod");
    set_id(1, 5'd5, 1, 5'd5, 1, 5'd8, C_ADD);
    step("alu.cons");
    step("alu.cap");

    // Hold over a hazard for 3 cycles, then release
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, C_LW);
    step("hold.lw");
    set_id(1, 5'd2, 1, 5'd5, 1, 5'd9, C_ADD);
    ifc.hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold.stall", 32'(ifc.stall_o), 32'd1);
      step("hold.frozen");
    end
    ifc.hold_i = 0;
    step("hold.bubble");
    step("hold.cap");
    chk("hold.rd_cap", 32'(ifc.rd_addr_ex_o), 32'd9);

    // Flush coinciding with a load-use
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, C_LW);
    step("flush.lw");
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, C_ADD);
    ifc.flush_i = 1;
    #1 chk("flush.stall_lo", 32'(ifc.stall_o), 32'd0);
    step("flush.kill");
    ifc.flush_i = 0;
    set_id(1, 5'd3, 1, 5'd4, 1, 5'd10, C_ADD);
    step("flush.fresh");
    step("flush.cap");

    // Back-to-back dependent loads
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, C_LW);
    step("b2b.lw1");
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, C_LW);
    step("b2b.lw2_stall");
    step("b2b.lw2_cap");
    set_id(1, 5'd6, 1, 5'd0, 0, 5'd7, C_ADD);
    step("b2b.add_stall");
    step("b2b.add_cap");

    // Reset asserted mid-stall clears asynchronously
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, C_LW);
    step("rst.lw");
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, C_ADD);
    #1 chk("rst.pre", 32'(ifc.stall_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rst.stall", 32'(ifc.stall_o), 32'd0);
    chk("rst.valid", 32'(ifc.valid_ex_o), 32'd0);
    m_reset();
    @(negedge clk);
    rst_i = 1'b1;
    step("rst.release");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      ifc.hold_i  = ($urandom_range(0, 9) == 0);
      ifc.flush_i = ($urandom_range(0, 9) == 0);
      step("rand");
    end
    ifc.hold_i = 0; ifc.flush_i = 0;

`ifdef ID_EX_STALL_CNT_EN
    // Counter saturation from a preloaded near-max value
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 2; i++) begin
      set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, C_LW);
      step("sat.lw");
      set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, C_ADD);
      step("sat.stall");
      step("sat.cap");
    end
    chk("sat.max", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
